// File: rtl/picoNISC_pkg.sv
// Shared types and helpers for the picoNISC control-word fetch path.
package picoNISC_pkg;

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        PRESENT
    } fetch_state_t;

    // Width of a beat index; a single-beat word still needs one bit.
    function automatic int beatIdxW(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/cw_assembler.sv
// Collects ROM beats into one wide control word, one Mwidth slot per beat.
module cw_assembler
    import picoNISC_pkg::*;
#(
    parameter int Mwidth = 8,
    parameter int Beats  = 4
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         i_we,
    input  logic [beatIdxW(Beats)-1:0]   i_slot,
    input  logic [Mwidth-1:0]            i_data,
    output logic [Mwidth*Beats-1:0]      o_word
);

    localparam int BW = beatIdxW(Beats);

    logic [Mwidth*Beats-1:0] r_word;

    // Beat k lands in bits [k*Mwidth +: Mwidth], little-endian.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_word <= '0;
        end else begin
            for (int k = 0; k < Beats; k++) begin
                if (i_we && (i_slot == BW'(k))) begin
                    r_word[k*Mwidth +: Mwidth] <= i_data;
                end
            end
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/cw_fetch.sv
// Fetches one wide control word per PC value from a narrow synchronous ROM
// and presents it to the datapath, releasing the PC exactly once per word.
module cw_fetch
    import picoNISC_pkg::*;
#(
    parameter int Psize  = 4,
    parameter int Mwidth = 8,
    parameter int Beats  = 4
) (
    input  logic                                clk,
    input  logic                                Reset,
    input  logic [Psize-1:0]                    pc_in,
    output logic                                hold,
    output logic                                mem_rd,
    output logic [Psize+beatIdxW(Beats)-1:0]    mem_addr,
    input  logic [Mwidth-1:0]                   mem_data,
    input  logic                                stall,
    output logic [Mwidth*Beats-1:0]             cw,
    output logic                                cw_valid
);

    localparam int BW = beatIdxW(Beats);
    localparam int AW = Psize + BW;
    localparam logic [BW-1:0] LastBeat = BW'(Beats - 1);

    fetch_state_t    r_state;
    fetch_state_t    w_nextState;
    logic [BW-1:0]   r_beat;
    logic [BW-1:0]   r_rdBeat;
    logic            r_rdPending;
    logic [Psize-1:0] r_pcLatched;
    logic [AW-1:0]   r_addrLast;
    logic [AW-1:0]   w_addr;
    logic            w_memRd;
    logic            w_hold;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Beat 0 addresses straight from pc_in since pc_latched is only being loaded now.
    always_comb begin
        w_nextState = r_state;
        w_memRd     = 1'b0;
        w_hold      = 1'b1;
        w_addr      = r_addrLast;
        case (r_state)
            FETCH: begin
                w_memRd = 1'b1;
                w_addr  = (r_beat == '0) ? {pc_in, r_beat} : {r_pcLatched, r_beat};
                if (r_beat == LastBeat) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                w_nextState = PRESENT;
            end
            PRESENT: begin
                if (!stall) begin
                    w_hold      = 1'b0;
                    w_nextState = FETCH;
                end
            end
            default: begin
                w_nextState = FETCH;
            end
        endcase
        if (Reset) begin
            w_memRd = 1'b0;
            w_hold  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_beat      <= '0;
            r_rdBeat    <= '0;
            r_rdPending <= 1'b0;
            r_pcLatched <= '0;
            r_addrLast  <= '0;
        end else begin
            r_rdPending <= w_memRd;
            r_rdBeat    <= r_beat;
            if (w_memRd) begin
                r_addrLast <= w_addr;
            end
            if (r_state == FETCH) begin
                r_beat <= (r_beat == LastBeat) ? '0 : r_beat + 1'b1;
                if (r_beat == '0) begin
                    r_pcLatched <= pc_in;
                end
            end
        end
    end

    cw_assembler #(
        .Mwidth (Mwidth),
        .Beats  (Beats)
    ) u_assembler (
        .clk    (clk),
        .Reset  (Reset),
        .i_we   (r_rdPending),
        .i_slot (r_rdBeat),
        .i_data (mem_data),
        .o_word (cw)
    );

    assign mem_rd   = w_memRd;
    assign mem_addr = w_addr;
    assign hold     = w_hold;
    assign cw_valid = (r_state == PRESENT);

endmodule

// File: tb/tb_cw_fetch.sv
// Directed bench for cw_fetch with a mem[a]=a ROM and a PC model driven by hold.
module tb_cw_fetch;

    localparam int Psize  = 4;
    localparam int Mwidth = 8;
    localparam int Beats  = 4;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  pc = 4'd0;
    logic        hold;
    logic        mem_rd;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_data = 8'd0;
    logic        stall = 1'b0;
    logic [31:0] cw;
    logic        cw_valid;
    logic        pcLoad = 1'b0;
    logic [3:0]  pcLoadVal = 4'd0;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    cw_fetch #(
        .Psize  (Psize),
        .Mwidth (Mwidth),
        .Beats  (Beats)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .pc_in    (pc),
        .hold     (hold),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .stall    (stall),
        .cw       (cw),
        .cw_valid (cw_valid)
    );

    // Synchronous ROM, data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= {2'b00, mem_addr};
    end

    // PC: preload wins, then reset, otherwise advance when hold is low.
    always @(posedge clk) begin
        if (pcLoad) pc <= pcLoadVal;
        else if (Reset) pc <= 4'd0;
        else if (!hold) pc <= pc + 4'd1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        tick();
        tick();
        compared++; if (mem_rd !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_rd got %b want 0", mem_rd); end
        compared++; if (hold !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_hold got %b want 1", hold); end
        compared++; if (cw_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_cw_valid got %b want 0", cw_valid); end
        compared++; if (cw !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_cw got %h want 00000000", cw); end
        Reset = 1'b0;
        #1;
    endtask

    task automatic test_first_word;
        for (int c = 0; c < 6; c++) begin
            compared++; if (mem_rd !== (c < 4)) begin mismatched++; $display("[TB] FAIL w1_mem_rd c%0d got %b", c, mem_rd); end
            if (c < 4) begin
                compared++; if (mem_addr !== 6'(c)) begin mismatched++; $display("[TB] FAIL w1_addr c%0d got %0d want %0d", c, mem_addr, c); end
            end
            compared++; if (cw_valid !== (c == 5)) begin mismatched++; $display("[TB] FAIL w1_valid c%0d got %b", c, cw_valid); end
            compared++; if (hold !== (c != 5)) begin mismatched++; $display("[TB] FAIL w1_hold c%0d got %b", c, hold); end
            if (c == 5) begin
                compared++; if (cw !== 32'h03020100) begin mismatched++; $display("[TB] FAIL w1_cw got %h want 03020100", cw); end
            end
            tick();
        end
        compared++; if (pc !== 4'd1) begin mismatched++; $display("[TB] FAIL w1_pc got %0d want 1", pc); end
    endtask

    task automatic test_back_to_back;
        compared++; if (cw !== 32'h03020100) begin mismatched++; $display("[TB] FAIL b2b_cw_kept got %h want 03020100", cw); end
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                compared++; if (mem_addr !== 6'(4 + c)) begin mismatched++; $display("[TB] FAIL b2b_addr c%0d got %0d want %0d", c, mem_addr, 4 + c); end
            end
            compared++; if (cw_valid !== (c == 5)) begin mismatched++; $display("[TB] FAIL b2b_valid c%0d got %b", c, cw_valid); end
            if (c == 5) begin
                compared++; if (cw !== 32'h07060504) begin mismatched++; $display("[TB] FAIL b2b_cw got %h want 07060504", cw); end
            end
            tick();
        end
        compared++; if (pc !== 4'd2) begin mismatched++; $display("[TB] FAIL b2b_pc got %0d want 2", pc); end
    endtask

    task automatic test_stall;
        stall = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                compared++; if (mem_addr !== 6'(8 + c)) begin mismatched++; $display("[TB] FAIL stall_addr c%0d got %0d want %0d", c, mem_addr, 8 + c); end
            end
            compared++; if (cw_valid !== (c >= 5)) begin mismatched++; $display("[TB] FAIL stall_valid c%0d got %b", c, cw_valid); end
            compared++; if (hold !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_hold c%0d got %b want 1", c, hold); end
            compared++; if (pc !== 4'd2) begin mismatched++; $display("[TB] FAIL stall_pc c%0d got %0d want 2", c, pc); end
            if (c >= 5) begin
                compared++; if (cw !== 32'h0B0A0908) begin mismatched++; $display("[TB] FAIL stall_cw c%0d got %h want 0b0a0908", c, cw); end
            end
            tick();
        end
        stall = 1'b0;
        #1;
        compared++; if (hold !== 1'b0) begin mismatched++; $display("[TB] FAIL release_hold got %b want 0", hold); end
        compared++; if (cw_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL release_valid got %b want 1", cw_valid); end
        tick();
        compared++; if (hold !== 1'b1) begin mismatched++; $display("[TB] FAIL after_release_hold got %b want 1", hold); end
        compared++; if (cw_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL after_release_valid got %b want 0", cw_valid); end
        compared++; if (pc !== 4'd3) begin mismatched++; $display("[TB] FAIL after_release_pc got %0d want 3", pc); end
    endtask

    task automatic test_wrap;
        logic [3:0]  expPc [2];
        logic [31:0] expCw [2];
        expPc[0] = 4'd15; expCw[0] = 32'h3F3E3D3C;
        expPc[1] = 4'd0;  expCw[1] = 32'h03020100;
        Reset = 1'b1;
        pcLoad = 1'b1;
        pcLoadVal = 4'd15;
        tick();
        pcLoad = 1'b0;
        Reset = 1'b0;
        #1;
        for (int w = 0; w < 2; w++) begin
            for (int c = 0; c < 6; c++) begin
                if (c < 4) begin
                    compared++; if (mem_addr !== {expPc[w], 2'(c)}) begin mismatched++; $display("[TB] FAIL wrap_addr w%0d c%0d got %0d want %0d", w, c, mem_addr, {expPc[w], 2'(c)}); end
                end
                if (c == 5) begin
                    compared++; if (cw !== expCw[w]) begin mismatched++; $display("[TB] FAIL wrap_cw w%0d got %h want %h", w, cw, expCw[w]); end
                end
                tick();
            end
        end
        compared++; if (pc !== 4'd1) begin mismatched++; $display("[TB] FAIL wrap_pc got %0d want 1", pc); end
    endtask

    task automatic test_midfetch_pc;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                compared++; if (mem_addr !== 6'(4 + c)) begin mismatched++; $display("[TB] FAIL mid_addr c%0d got %0d want %0d", c, mem_addr, 4 + c); end
            end
            if (c == 5) begin
                compared++; if (cw !== 32'h07060504) begin mismatched++; $display("[TB] FAIL mid_cw got %h want 07060504", cw); end
            end
            if (c == 1) begin
                pcLoad = 1'b1;
                pcLoadVal = 4'd9;
            end
            if (c == 2) pcLoad = 1'b0;
            tick();
        end
        compared++; if (pc !== 4'd10) begin mismatched++; $display("[TB] FAIL mid_pc got %0d want 10", pc); end
    endtask

    task automatic test_reset_mid;
        compared++; if (mem_addr !== 6'd40) begin mismatched++; $display("[TB] FAIL rmid_addr0 got %0d want 40", mem_addr); end
        tick();
        Reset = 1'b1;
        #1;
        tick();
        compared++; if (mem_rd !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_mem_rd got %b want 0", mem_rd); end
        compared++; if (cw !== 32'h0) begin mismatched++; $display("[TB] FAIL rmid_cw got %h want 00000000", cw); end
        compared++; if (cw_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_valid got %b want 0", cw_valid); end
        compared++; if (hold !== 1'b1) begin mismatched++; $display("[TB] FAIL rmid_hold got %b want 1", hold); end
        Reset = 1'b0;
        #1;
        compared++; if (mem_addr !== 6'd0 || mem_rd !== 1'b1) begin mismatched++; $display("[TB] FAIL rmid_restart got addr %0d rd %b want 0 1", mem_addr, mem_rd); end
        tick();
        compared++; if (cw !== 32'h0) begin mismatched++; $display("[TB] FAIL rmid_stale got %h want 00000000", cw); end
        compared++; if (mem_addr !== 6'd1) begin mismatched++; $display("[TB] FAIL rmid_addr1 got %0d want 1", mem_addr); end
        for (int c = 1; c < 5; c++) tick();
        compared++; if (cw_valid !== 1'b1 || cw !== 32'h03020100) begin mismatched++; $display("[TB] FAIL rmid_cw_final got %h valid %b want 03020100 1", cw, cw_valid); end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_midfetch_pc();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout got no finish want finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
